// File: rtl/ram_responder_if.sv
// ram_responder_if: RAM-side bus between the memory controller and the RAM responder.
//   cpu_types_pkg : ramstate_t handshake encoding (FREE, BUSY, ACCESS, ERROR).
//   ramaddr  : byte address, word index = ramaddr[31:2]   (controller -> RAM)
//   ramstore : write data                                   (controller -> RAM)
//   ramREN   : read request                                 (controller -> RAM)
//   ramWEN   : write request                                (controller -> RAM)
//   ramload  : read data, valid in ACCESS of a read         (RAM -> controller)
//   ramstate : handshake state                              (RAM -> controller)
package cpu_types_pkg;
    typedef enum logic [1:0] {FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3} ramstate_t;
endpackage

interface ram_responder_if;
    import cpu_types_pkg::*;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramload;
    ramstate_t   ramstate;
    modport master (output ramaddr, ramstore, ramREN, ramWEN, input ramload, ramstate);
    modport slave  (input ramaddr, ramstore, ramREN, ramWEN, output ramload, ramstate);
endinterface

// File: rtl/ram_responder.sv
// ram_responder: single-port word RAM answering the memory controller with LAT BUSY cycles per access.
//   CLK : clock, all state updates on the rising edge
//   RST : synchronous active-high reset (clears state, latches and every memory word)
//   bus : ram_responder_if.slave (ramaddr/ramstore/ramREN/ramWEN in, ramload/ramstate out)
//   DEPTH : number of 32-bit words, LAT : BUSY cycles before each ACCESS
module ram_responder #(
    parameter int DEPTH = 1024,
    parameter int LAT   = 2
) (
    input logic CLK,
    input logic RST,
    ram_responder_if.slave bus
);
    import cpu_types_pkg::*;

    localparam int CW = (LAT > 0) ? $clog2(LAT + 1) : 1;
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'((LAT > 0) ? LAT - 1 : 0);

    ramstate_t     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          op_q, op_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [31:0]   data_q, data_d;
    logic [31:0]   mem [DEPTH];
    logic          req, illegal, changed;

    assign req     = bus.ramREN | bus.ramWEN;
    assign illegal = (bus.ramREN & bus.ramWEN) | (bus.ramaddr[1:0] != 2'b00) |
                     ({2'b00, bus.ramaddr[31:2]} >= 32'(DEPTH));
    // Only consulted for legal requests, whose address fits entirely in the word index.
    assign changed = (op_q != bus.ramWEN) | (addr_q != bus.ramaddr[AW+1:2]) | (data_q != bus.ramstore);

    // Every state except an unchanged BUSY evaluates the live request exactly as FREE does.
    // An illegal request can never match a latched (legal) one, so it always lands in ERROR.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        addr_d  = addr_q;
        data_d  = data_q;
        if (!req) begin
            state_d = FREE;
        end else if (illegal) begin
            state_d = ERROR;
        end else if (state_q != BUSY || changed) begin
            state_d = (LAT == 0) ? ACCESS : BUSY;
            cnt_d   = CNT_LOAD;
            op_d    = bus.ramWEN;
            addr_d  = bus.ramaddr[AW+1:2];
            data_d  = bus.ramstore;
        end else if (cnt_q == '0) begin
            state_d = ACCESS;
        end else begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= FREE;
            cnt_q   <= '0;
            op_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            // Writes commit on the edge that ends ACCESS, so a reset during the access drops them.
            if (state_q == ACCESS && op_q) mem[addr_q] <= data_q;
        end
    end

    assign bus.ramstate = state_q;
    assign bus.ramload  = (state_q == ACCESS && !op_q) ? mem[addr_q] : 32'h0;
endmodule

// File: tb/tb_ram_responder.sv
// tb_ram_responder: checks ram_responder (LAT=2 against a cycle-count model, LAT=0 by hand sequence).
//   Drives two DUT instances through their own ram_responder_if interfaces; prints one summary line.
module tb_ram_responder;
    import cpu_types_pkg::*;

    localparam int LAT2 = 2;
    localparam logic [1:0] F = 2'd0, B = 2'd1, A = 2'd2, E = 2'd3;

    typedef struct {
        logic        ren;
        logic        wen;
        logic [31:0] a;
        logic [31:0] d;
        logic [1:0]  st;
        logic [31:0] ld;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;

    ram_responder_if bus2 ();
    ram_responder_if bus0 ();

    ram_responder #(.DEPTH(1024), .LAT(2)) u_dut2 (.CLK(clk), .RST(rst), .bus(bus2.slave));
    ram_responder #(.DEPTH(1024), .LAT(0)) u_dut0 (.CLK(clk), .RST(rst), .bus(bus0.slave));

    always #5 clk = ~clk;

    // Reference model for the LAT=2 instance: counts how many consecutive cycles the same
    // legal request has been in progress; ACCESS once that count exceeds LAT.
    logic [1:0]  m_st = F;
    int          m_since = 0;
    logic        m_wr = 1'b0;
    logic [31:0] m_addr = '0, m_data = '0, m_ld = '0;
    logic [31:0] mm [int];

    function automatic logic [31:0] rd_mem(input logic [31:0] a);
        return mm.exists(int'(a >> 2)) ? mm[int'(a >> 2)] : 32'h0;
    endfunction

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endfunction

    task automatic model_edge(input logic ren, input logic wen, input logic [31:0] a, input logic [31:0] d,
                              input logic r);
        if (r) begin
            m_st = F;
            m_since = 0;
            m_wr = 1'b0;
            m_addr = '0;
            m_data = '0;
            mm.delete();
        end else begin
            if (m_st == A && m_wr) mm[int'(m_addr >> 2)] = m_data;
            if (!(ren | wen)) begin
                m_st = F;
            end else if ((ren & wen) || a[1:0] != 2'b00 || (a >> 2) >= 32'd1024) begin
                m_st = E;
            end else begin
                if (m_st != B || m_wr != wen || m_addr != a || m_data != d) begin
                    m_since = 0;
                    m_wr = wen;
                    m_addr = a;
                    m_data = d;
                end
                m_since++;
                m_st = (m_since > LAT2) ? A : B;
            end
        end
        m_ld = (m_st == A && !m_wr) ? rd_mem(m_addr) : 32'h0;
    endtask

    task automatic step(input logic ren, input logic wen, input logic [31:0] a, input logic [31:0] d,
                        input logic r);
        bus2.ramREN = ren;
        bus2.ramWEN = wen;
        bus2.ramaddr = a;
        bus2.ramstore = d;
        rst = r;
        @(posedge clk);
        model_edge(ren, wen, a, d, r);
        #1;
        chk("model_state", bus2.ramstate, m_st);
        chk("model_load", bus2.ramload, m_ld);
    endtask

    task automatic step0(input logic ren, input logic wen, input logic [31:0] a, input logic [31:0] d,
                         input logic [1:0] st, input logic [31:0] ld, input string nm);
        bus0.ramREN = ren;
        bus0.ramWEN = wen;
        bus0.ramaddr = a;
        bus0.ramstore = d;
        @(posedge clk);
        #1;
        chk({nm, "_state"}, bus0.ramstate, st);
        chk({nm, "_load"}, bus0.ramload, ld);
    endtask

    vec_t tbl [$];

    initial begin
        logic        cr, cw;
        logic [31:0] ca, cd;
        bus0.ramREN = 1'b0;
        bus0.ramWEN = 1'b0;
        bus0.ramaddr = '0;
        bus0.ramstore = '0;

        // write 0x40 then read it back
        tbl.push_back('{1'b0, 1'b1, 32'h40, 32'hDEADBEEF, B, 32'h0});
        tbl.push_back('{1'b0, 1'b1, 32'h40, 32'hDEADBEEF, B, 32'h0});
        tbl.push_back('{1'b0, 1'b1, 32'h40, 32'hDEADBEEF, A, 32'h0});
        tbl.push_back('{1'b0, 1'b0, 32'h0,  32'h0,        F, 32'h0});
        tbl.push_back('{1'b0, 1'b0, 32'h0,  32'h0,        F, 32'h0});
        tbl.push_back('{1'b1, 1'b0, 32'h40, 32'h0,        B, 32'h0});
        tbl.push_back('{1'b1, 1'b0, 32'h40, 32'h0,        B, 32'h0});
        tbl.push_back('{1'b1, 1'b0, 32'h40, 32'h0,        A, 32'hDEADBEEF});
        // two-word writeback, second word presented during the first ACCESS
        tbl.push_back('{1'b0, 1'b1, 32'h80, 32'h11111111, B, 32'h0});
        tbl.push_back('{1'b0, 1'b1, 32'h80, 32'h11111111, B, 32'h0});
        tbl.push_back('{1'b0, 1'b1, 32'h80, 32'h11111111, A, 32'h0});
        tbl.push_back('{1'b0, 1'b1, 32'h84, 32'h22222222, B, 32'h0});
        tbl.push_back('{1'b0, 1'b1, 32'h84, 32'h22222222, B, 32'h0});
        tbl.push_back('{1'b0, 1'b1, 32'h84, 32'h22222222, A, 32'h0});
        tbl.push_back('{1'b0, 1'b0, 32'h0,  32'h0,        F, 32'h0});
        tbl.push_back('{1'b1, 1'b0, 32'h80, 32'h0,        B, 32'h0});
        tbl.push_back('{1'b1, 1'b0, 32'h80, 32'h0,        B, 32'h0});
        tbl.push_back('{1'b1, 1'b0, 32'h80, 32'h0,        A, 32'h11111111});
        tbl.push_back('{1'b1, 1'b0, 32'h84, 32'h0,        B, 32'h0});
        tbl.push_back('{1'b1, 1'b0, 32'h84, 32'h0,        B, 32'h0});
        tbl.push_back('{1'b1, 1'b0, 32'h84, 32'h0,        A, 32'h22222222});
        tbl.push_back('{1'b0, 1'b0, 32'h0,  32'h0,        F, 32'h0});
        // illegal requests, each ERROR for one cycle
        tbl.push_back('{1'b1, 1'b1, 32'h40,   32'h0BADBAD0, E, 32'h0});
        tbl.push_back('{1'b0, 1'b0, 32'h0,    32'h0,        F, 32'h0});
        tbl.push_back('{1'b0, 1'b1, 32'h42,   32'h0BADBAD1, E, 32'h0});
        tbl.push_back('{1'b0, 1'b0, 32'h0,    32'h0,        F, 32'h0});
        tbl.push_back('{1'b0, 1'b1, 32'h1000, 32'h0BADBAD2, E, 32'h0});
        tbl.push_back('{1'b0, 1'b0, 32'h0,    32'h0,        F, 32'h0});
        tbl.push_back('{1'b1, 1'b0, 32'h40,   32'h0,        B, 32'h0});
        tbl.push_back('{1'b1, 1'b0, 32'h40,   32'h0,        B, 32'h0});
        tbl.push_back('{1'b1, 1'b0, 32'h40,   32'h0,        A, 32'hDEADBEEF});
        tbl.push_back('{1'b0, 1'b0, 32'h0,    32'h0,        F, 32'h0});
        // restart on address change, then abort on drop
        tbl.push_back('{1'b1, 1'b0, 32'h100, 32'h0, B, 32'h0});
        tbl.push_back('{1'b1, 1'b0, 32'h100, 32'h0, B, 32'h0});
        tbl.push_back('{1'b1, 1'b0, 32'h104, 32'h0, B, 32'h0});
        tbl.push_back('{1'b1, 1'b0, 32'h104, 32'h0, B, 32'h0});
        tbl.push_back('{1'b1, 1'b0, 32'h104, 32'h0, A, 32'h0});
        tbl.push_back('{1'b0, 1'b0, 32'h0,   32'h0, F, 32'h0});
        tbl.push_back('{1'b1, 1'b0, 32'h100, 32'h0, B, 32'h0});
        tbl.push_back('{1'b1, 1'b0, 32'h100, 32'h0, B, 32'h0});
        tbl.push_back('{1'b0, 1'b0, 32'h0,   32'h0, F, 32'h0});
        tbl.push_back('{1'b0, 1'b0, 32'h0,   32'h0, F, 32'h0});

        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        chk("reset_state", bus2.ramstate, F);
        chk("reset_load", bus2.ramload, 32'h0);

        foreach (tbl[i]) begin
            step(tbl[i].ren, tbl[i].wen, tbl[i].a, tbl[i].d, 1'b0);
            chk($sformatf("vec%0d_state", i), bus2.ramstate, tbl[i].st);
            chk($sformatf("vec%0d_load", i), bus2.ramload, tbl[i].ld);
        end

        // reset mid-traffic clears memory: 0x40 held DEADBEEF before
        step(1'b0, 1'b1, 32'h40, 32'h55555555, 1'b0);
        step(1'b0, 1'b1, 32'h40, 32'h55555555, 1'b1);
        chk("rst_mid_state", bus2.ramstate, F);
        chk("rst_mid_load", bus2.ramload, 32'h0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h40, 32'h0, 1'b0);
        chk("rst_read40_state", bus2.ramstate, A);
        chk("rst_read40_load", bus2.ramload, 32'h0);
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);

        // reset during BUSY of a write: write never commits
        step(1'b0, 1'b1, 32'h200, 32'hCAFEF00D, 1'b0);
        step(1'b0, 1'b1, 32'h200, 32'hCAFEF00D, 1'b0);
        chk("wr_busy_state", bus2.ramstate, B);
        step(1'b0, 1'b1, 32'h200, 32'hCAFEF00D, 1'b1);
        chk("rst_wr_state", bus2.ramstate, F);
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h200, 32'h0, 1'b0);
        chk("rst_read200_state", bus2.ramstate, A);
        chk("rst_read200_load", bus2.ramload, 32'h0);

        // randomized traffic against the model
        cr = 1'b0; cw = 1'b0; ca = '0; cd = '0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) >= 7) begin
                int k;
                k = int'($urandom_range(0, 9));
                cd = $urandom;
                if (k < 2) begin
                    cr = 1'b0; cw = 1'b0;
                end else if (k == 2) begin
                    int j;
                    j = int'($urandom_range(0, 2));
                    cr = (j != 1); cw = (j != 2);
                    ca = (j == 0) ? 32'h40 : (j == 1) ? 32'h46 : 32'h1000 + 32'($urandom_range(0, 3)) * 4;
                end else begin
                    cw = $urandom_range(0, 1) == 1;
                    cr = !cw;
                    ca = 32'h40 + 32'($urandom_range(0, 3)) * 4;
                end
            end
            step(cr, cw, ca, cd, i == 250);
        end

        // LAT=0: ACCESS the cycle after the request and every cycle while held
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        step0(1'b0, 1'b1, 32'h40, 32'h12345678, A, 32'h0, "l0_write");
        step0(1'b1, 1'b0, 32'h40, 32'h0, A, 32'h12345678, "l0_read1");
        step0(1'b1, 1'b0, 32'h40, 32'h0, A, 32'h12345678, "l0_read2");
        step0(1'b1, 1'b0, 32'h40, 32'h0, A, 32'h12345678, "l0_read3");
        step0(1'b1, 1'b1, 32'h40, 32'h0, E, 32'h0, "l0_err");
        step0(1'b0, 1'b0, 32'h0, 32'h0, F, 32'h0, "l0_idle");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
